// File: rtl/uart_16550_pkg.sv
// Shared definitions for the UART 16550 receive interrupt logic:
// timeout FSM encoding, FCR trigger-level decode and character timing.
package uart_16550_pkg;

    // Timeout FSM state encoding
    localparam logic [1:0] TO_IDLE    = 2'b00;
    localparam logic [1:0] TO_ARMED   = 2'b01;
    localparam logic [1:0] TO_EXPIRED = 2'b10;

    // FCR[7:6] trigger levels in characters
    localparam logic [3:0] RX_TRIG_1  = 4'd1;
    localparam logic [3:0] RX_TRIG_4  = 4'd4;
    localparam logic [3:0] RX_TRIG_8  = 4'd8;
    localparam logic [3:0] RX_TRIG_14 = 4'd14;

    // One character lasts 16 ticks per bit; timeout is four characters idle
    localparam int CHAR_TICKS    = 16;
    localparam int TIMEOUT_CHARS = 4;

    function automatic logic [3:0] rx_trig_value(input logic [1:0] sel);
        logic [3:0] val;
        case (sel)
            2'b00:   val = RX_TRIG_1;
            2'b01:   val = RX_TRIG_4;
            2'b10:   val = RX_TRIG_8;
            default: val = RX_TRIG_14;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/uart_16550_rx_timeout.sv
// Character-timeout detector: frame-length decode, idle tick counter and
// the IDLE/ARMED/EXPIRED state machine. The state register is exposed so
// the parent (and any checker) can observe it directly.
module uart_16550_rx_timeout
    import uart_16550_pkg::*;
#(
    parameter int TO_CNT_W = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_en,
    input  logic       flush,
    input  logic [1:0] word_len,
    input  logic       stop_bits,
    input  logic       parity_en,
    input  logic       tick,
    input  logic       push,
    input  logic       pop,
    input  logic       pop_empties,
    input  logic       fifo_empty,
    output logic [1:0] state
);

    localparam int TO_MULT = CHAR_TICKS * TIMEOUT_CHARS;

    logic [3:0]          frame_bits;
    logic [TO_CNT_W-1:0] threshold;
    logic [TO_CNT_W-1:0] cnt;
    logic [TO_CNT_W-1:0] cnt_inc;

    // start + data + parity + stop bits, recomputed live so LCR edits apply at once
    assign frame_bits = 4'd7 + {2'b00, word_len} + {3'b000, parity_en} + {3'b000, stop_bits};
    assign threshold  = TO_CNT_W'(int'(frame_bits) * TO_MULT);
    assign cnt_inc    = cnt + TO_CNT_W'(1);

    // Idle-time tracking; >= compare lets a shortened threshold expire on the next tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TO_IDLE;
            cnt   <= '0;
        end else if (flush || !fifo_en) begin
            state <= TO_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                TO_IDLE: begin
                    cnt <= '0;
                    if (!fifo_empty && !push && !pop)
                        state <= TO_ARMED;
                end
                TO_ARMED: begin
                    if (fifo_empty) begin
                        state <= TO_IDLE;
                        cnt   <= '0;
                    end else if (push || pop) begin
                        cnt <= '0;
                    end else if (tick) begin
                        cnt <= cnt_inc;
                        if (cnt_inc >= threshold)
                            state <= TO_EXPIRED;
                    end
                end
                TO_EXPIRED: begin
                    // only a read clears the interrupt; pushes leave it pending
                    if (pop) begin
                        cnt   <= '0;
                        state <= pop_empties ? TO_IDLE : TO_ARMED;
                    end
                end
                default: begin
                    state <= TO_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_16550_rx_irq_ctrl.sv
// Receive interrupt/status controller for the UART 16550 Rx FIFO:
// data-available interrupt, character-timeout interrupt and LSR[7]
// (errored entries resident in the FIFO).
// Build option: define UART_RX_TIMEOUT_INT_EN to build the timeout logic;
// without it Rx_Timeout_Int_o is tied low.
module uart_16550_rx_irq_ctrl
    import uart_16550_pkg::*;
#(
    parameter int LEVEL_W  = 9,
    parameter int TO_CNT_W = 10
) (
    input  logic               WBs_CLK_i,
    input  logic               WBs_RST_i,
    input  logic               Rx_FIFO_Enable_i,
    input  logic               Rx_FIFO_Flush_i,
    input  logic [1:0]         Rx_Trigger_Level_i,
    input  logic [1:0]         Rx_Word_Len_i,
    input  logic               Rx_Stop_Bits_i,
    input  logic               Rx_Parity_En_i,
    input  logic               Baud_16x_Tick_i,
    input  logic               Rx_FIFO_Push_i,
    input  logic               Rx_Err_Push_i,
    input  logic               Rx_FIFO_Pop_i,
    input  logic               Rx_Err_Pop_i,
    input  logic [LEVEL_W-1:0] Rx_FIFO_Level_i,
    input  logic               Rx_FIFO_Empty_i,
    output logic               Rx_Data_Avail_Int_o,
    output logic               Rx_Timeout_Int_o,
    output logic               Rx_FIFO_Err_o,
    output logic [LEVEL_W-1:0] Rx_Err_Count_o
);

    logic               err_inc;
    logic               err_dec;
    logic [LEVEL_W-1:0] err_next;

    assign err_inc = Rx_FIFO_Push_i && Rx_Err_Push_i;
    assign err_dec = Rx_FIFO_Pop_i  && Rx_Err_Pop_i;

    // Data-available: trigger compare in FIFO mode, non-empty in 16450 mode
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i)
            Rx_Data_Avail_Int_o <= 1'b0;
        else if (Rx_FIFO_Flush_i)
            Rx_Data_Avail_Int_o <= 1'b0;
        else if (Rx_FIFO_Enable_i)
            Rx_Data_Avail_Int_o <= (Rx_FIFO_Level_i >= LEVEL_W'(rx_trig_value(Rx_Trigger_Level_i)));
        else
            Rx_Data_Avail_Int_o <= !Rx_FIFO_Empty_i;
    end

    // Next errored-entry count: flush wins, saturating at both ends
    always_comb begin
        err_next = Rx_Err_Count_o;
        if (Rx_FIFO_Flush_i || !Rx_FIFO_Enable_i)
            err_next = '0;
        else if (err_inc && !err_dec && (Rx_Err_Count_o != '1))
            err_next = Rx_Err_Count_o + LEVEL_W'(1);
        else if (err_dec && !err_inc && (Rx_Err_Count_o != '0))
            err_next = Rx_Err_Count_o - LEVEL_W'(1);
    end

    // Register the count and LSR[7] together so they never disagree
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            Rx_Err_Count_o <= '0;
            Rx_FIFO_Err_o  <= 1'b0;
        end else begin
            Rx_Err_Count_o <= err_next;
            Rx_FIFO_Err_o  <= (err_next != '0);
        end
    end

`ifdef UART_RX_TIMEOUT_INT_EN
    logic [1:0] to_state;
    logic       pop_empties;

    // a pop of the last entry with no refilling push leaves the FIFO empty
    assign pop_empties = (Rx_FIFO_Level_i == LEVEL_W'(1)) && !Rx_FIFO_Push_i;

    uart_16550_rx_timeout #(
        .TO_CNT_W (TO_CNT_W)
    ) u_rx_timeout (
        .clk         (WBs_CLK_i),
        .rst         (WBs_RST_i),
        .fifo_en     (Rx_FIFO_Enable_i),
        .flush       (Rx_FIFO_Flush_i),
        .word_len    (Rx_Word_Len_i),
        .stop_bits   (Rx_Stop_Bits_i),
        .parity_en   (Rx_Parity_En_i),
        .tick        (Baud_16x_Tick_i),
        .push        (Rx_FIFO_Push_i),
        .pop         (Rx_FIFO_Pop_i),
        .pop_empties (pop_empties),
        .fifo_empty  (Rx_FIFO_Empty_i),
        .state       (to_state)
    );

    // interrupt is a pure decode of the state register, no input paths
    assign Rx_Timeout_Int_o = (to_state == TO_EXPIRED);
`else
    logic unused_to_inputs;

    // timeout hardware not built; LCR and tick inputs are intentionally ignored
    assign unused_to_inputs = ^{Rx_Word_Len_i, Rx_Stop_Bits_i, Rx_Parity_En_i,
                                Baud_16x_Tick_i, TO_CNT_W[0]};
    assign Rx_Timeout_Int_o = 1'b0;
`endif

endmodule
